data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
// - Memory-side responder for the load/store FU's memReqStruct/memRespStruct interface.
// - Accepts one word request per cycle into a word-addressed data array.
// - Returns a memRespStruct-style response, tagged with robNum, after a fixed latency.
// - Responses pass through an output FIFO so the complete stage can stall.
//   req_ready is credit-based, so no response is ever dropped.
// PARAMETERS
// ADDR_BITS   6  word-index width; array holds 2**ADDR_BITS 32-bit words
// LATENCY     2  accept-to-response pipeline depth in cycles, legal range 1..8
// FIFO_DEPTH  4  output response FIFO entries, legal range 2..16
// PORTS
// clk            in   1   clock; every register updates on the rising edge
// rst_n          in   1   asynchronous active-low reset
// req_valid      in   1   memReqStruct.valid
// req_ready      out  1   responder can accept a request this cycle
// req_addr       in   32  memReqStruct.addr, a byte address
// req_wr_data    in   32  memReqStruct.wr_data
// req_MemWrite   in   1   memReqStruct.MemWrite
// req_MemRead    in   1   memReqStruct.MemRead
// req_robNum     in   4   ROB tag, returned unchanged on the response
// resp_valid     out  1   memRespStruct.valid; FIFO head is valid
// resp_ready     in   1   complete stage consumes the FIFO head
// resp_rd_data   out  32  memRespStruct.rd_data
// resp_MemWrite  out  1   memRespStruct.MemWrite, echoed from the request
// resp_MemRead   out  1   memRespStruct.MemRead, echoed from the request
// resp_robNum    out  4   tag of the FIFO head
// BEHAVIOUR
// Reset and handshakes
// - Reset, asynchronous on rst_n low: delay line, FIFO pointers and counters go to 0.
//   resp_* outputs all read 0; req_ready=1.
//   Array contents are NOT reset.
// - Accept: req_valid & req_ready at a rising edge.
//   A request that is not accepted has no effect.
// - Pop: resp_valid & resp_ready at a rising edge.
//   resp_* hold steady while resp_valid=1 and resp_ready=0.
// Array access
// - Word index = req_addr[ADDR_BITS+1:2].
//   addr[1:0] is ignored; upper bits are ignored, so the address wraps modulo the array size.
// - MemWrite=1: array[idx] <= wr_data on the accept edge; resp_rd_data=0.
//   This also applies when MemRead=1 is set too: the write wins.
// - MemRead=1, MemWrite=0: read happens on the accept edge.
//   It returns data including any write accepted on an earlier edge (read-after-write is exact).
// - Neither flag set: no array access; the response is still returned with rd_data=0.
// Latency and ordering
// - Request accepted on edge n: its response is at the FIFO head and resp_valid=1 in the cycle after edge n+LATENCY.
//   This holds when the FIFO was empty and nothing older is pending.
// - Responses leave in strict acceptance order.
// Credit and backpressure
// - credits_used = FIFO occupancy + requests in the delay line.
//   It is computed from registered state only.
// - req_ready = (credits_used < FIFO_DEPTH).
//   A pop in the same cycle does not free a credit until the next cycle.
// - Simultaneous accept and pop: occupancy and credit counters update consistently; no loss and no duplication.
// - FIFO full with resp_ready=0: req_ready=0 and in-flight entries drain into reserved slots.
//   Overflow is impossible by construction.
// - FIFO pointers wrap modulo FIFO_DEPTH.
// - Reset asserted mid-operation discards all in-flight and queued responses immediately.
// TESTING
// T1 Write then read:
//    - write addr 0x10, data 0xDEADBEEF, rob 3; next cycle read 0x10, rob 4.
//    - Expect resp (rob3, W=1, rd=0), then (rob4, R=1, rd=0xDEADBEEF).
//    - Each at +LATENCY from its accept.
// T2 Address aliasing:
//    - write 0x13 = 0x1; read 0x10 -> 0x1.
//    - With ADDR_BITS=6, read 0x110 -> 0x1 (wrap).
// T3 Backpressure:
//    - resp_ready=0; issue 6 reads back-to-back.
//    - Expect exactly FIFO_DEPTH=4 accepted, then req_ready=0.
//    - Raise resp_ready: robNums pop in order and req_ready returns 1 the cycle after the first pop.
// T4 Simultaneous accept and pop:
//    - resp_ready=1 with continuous reads for 20 cycles.
//    - Throughput 1/cycle, no tag lost or duplicated, and credits_used never exceeds 4.
// T5 Both flags set:
//    - MemRead=MemWrite=1 at addr 0x20, data 0x55.
//    - Expect rd_data=0 with both echoed as 1; a later read of 0x20 returns 0x55.
// T6 Reset mid-operation:
//    - assert rst_n=0 with 3 responses queued.
//    - resp_valid=0 immediately and req_ready=1 after release.
//    - Data written before reset is still readable.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-addressed data memory responder for the load/store unit.
// Fixed-latency responses queue in a credit-protected output FIFO.
module data_mem_responder #(
  parameter int ADDR_BITS  = 6,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wr_data,
  input  logic        req_MemWrite,
  input  logic        req_MemRead,
  input  logic [3:0]  req_robNum,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rd_data,
  output logic        resp_MemWrite,
  output logic        resp_MemRead,
  output logic [3:0]  resp_robNum
);

  localparam int WORDS = 1 << ADDR_BITS;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + LATENCY + 1);

  typedef struct packed {
    logic        v;
    logic [31:0] rd;
    logic        wr;
    logic        rdf;
    logic [3:0]  rob;
  } resp_t;

  logic [31:0]          mem  [WORDS];
  resp_t                dl   [LATENCY];
  resp_t                fifo [FIFO_DEPTH];
  logic [PW-1:0]        wptr;
  logic [PW-1:0]        rptr;
  logic [CW-1:0]        count;
  logic [CW-1:0]        inflight;
  logic [CW-1:0]        credits;
  logic [ADDR_BITS-1:0] idx;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 rd_en;
  resp_t                head;
  logic                 unused_bits;

  assign idx    = req_addr[ADDR_BITS+1:2];
  assign accept = req_valid & req_ready;
  assign rd_en  = req_MemRead & ~req_MemWrite;
  assign push   = dl[LATENCY-1].v;
  assign pop    = resp_valid & resp_ready;
  assign head   = fifo[rptr];

  assign unused_bits = ^{req_addr[31:ADDR_BITS+2],
                         req_addr[1:0], head.v};

  // Count requests still travelling through the delay line.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++)
      inflight = inflight + CW'(dl[i].v);
  end

  assign credits   = count + inflight;
  assign req_ready = credits < CW'(FIFO_DEPTH);

  assign resp_valid    = count != '0;
  assign resp_rd_data  = resp_valid ? head.rd : '0;
  assign resp_MemWrite = resp_valid & head.wr;
  assign resp_MemRead  = resp_valid & head.rdf;
  assign resp_robNum   = resp_valid ? head.rob : '0;

  // Data array: writes land on the accept edge, no reset.
  always_ff @(posedge clk) begin
    if (accept && req_MemWrite)
      mem[idx] <= req_wr_data;
  end

  // Delay line: stage 0 captures the read result at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++)
        dl[i] <= '0;
    end else begin
      if (accept) begin
        dl[0].v   <= 1'b1;
        dl[0].rd  <= rd_en ? mem[idx] : 32'h0;
        dl[0].wr  <= req_MemWrite;
        dl[0].rdf <= req_MemRead;
        dl[0].rob <= req_robNum;
      end else begin
        dl[0] <= '0;
      end
      for (int i = 1; i < LATENCY; i++)
        dl[i] <= dl[i-1];
    end
  end

  // FIFO storage: slot is always reserved by the credit scheme.
  always_ff @(posedge clk) begin
    if (push)
      fifo[wptr] <= dl[LATENCY-1];
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)
        wptr <= (wptr == PW'(FIFO_DEPTH-1)) ? '0 : wptr + PW'(1);
      if (pop)
        rptr <= (rptr == PW'(FIFO_DEPTH-1)) ? '0 : rptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
